// File: rtl/cache_control_p.sv
// cache_control_p
// Control FSM for the 2-way pipelined cache datapath.
// It sequences hits, victim writeback and line fill through the cacheline
// adaptor, and keeps saturating hit/miss/writeback counters.
//
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   mem_read, mem_write   : CPU request; both high is treated as a write
//   cache_hit, hit1       : stage-1 lookup result and the way that hit
//   lru_out, dirty_o      : LRU way of the set and that way's dirty bit
//   pmem_resp             : adaptor done, one-cycle pulse
//   pmem_read, pmem_write : line requests to the adaptor
//   source_sel, way_sel, tag_sel, addrmux_sel,
//   load_cache, load_dirty, dirty_in, load_lru : datapath controls
//   stall, stall_regs     : pipeline freeze and its one-cycle-delayed copy
//   hit_count, miss_count, wb_count : saturating performance counters
module cache_control_p #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             cache_hit,
  input  logic             hit1,
  input  logic             lru_out,
  input  logic             dirty_o,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             source_sel,
  output logic             way_sel,
  output logic             tag_sel,
  output logic             addrmux_sel,
  output logic             load_cache,
  output logic             load_dirty,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             stall,
  output logic             stall_regs,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    REFILL    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             victim_q, victim_d;
  logic             stall_regs_q, stall_regs_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;
  logic [CNT_W-1:0] wb_count_q, wb_count_d;
  logic             req;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign req = mem_read | mem_write;

  // Outputs are decoded straight from the state register so an async reset
  // drops an in-flight pmem request immediately. The victim way is captured
  // only on the miss transition, so LRU movement during the miss is ignored.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    source_sel   = 1'b0;
    way_sel      = 1'b0;
    tag_sel      = 1'b0;
    addrmux_sel  = 1'b0;
    load_cache   = 1'b0;
    load_dirty   = 1'b0;
    dirty_in     = 1'b0;
    load_lru     = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      COMPARE: begin
        if (req && cache_hit) begin
          way_sel     = hit1;
          load_lru    = 1'b1;
          hit_count_d = sat_inc(hit_count_q);
          if (mem_write) begin
            load_cache = 1'b1;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
        end else if (req) begin
          stall        = 1'b1;
          victim_d     = lru_out;
          miss_count_d = sat_inc(miss_count_q);
          state_d      = dirty_o ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        stall       = 1'b1;
        addrmux_sel = 1'b1;
        way_sel     = victim_q;
        pmem_write  = 1'b1;
        if (pmem_resp) begin
          wb_count_d = sat_inc(wb_count_q);
          state_d    = FILL;
        end
      end
      FILL: begin
        stall       = 1'b1;
        addrmux_sel = 1'b1;
        way_sel     = victim_q;
        tag_sel     = 1'b1;
        pmem_read   = 1'b1;
        if (pmem_resp) begin
          source_sel = 1'b1;
          load_cache = 1'b1;
          load_dirty = 1'b1;
          state_d    = REFILL;
        end
      end
      // One cycle for the held address to re-look-up; the hit then
      // completes back in COMPARE.
      REFILL: begin
        stall       = 1'b1;
        addrmux_sel = 1'b1;
        way_sel     = victim_q;
        state_d     = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  assign stall_regs_d = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COMPARE;
      victim_q     <= 1'b0;
      stall_regs_q <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      stall_regs_q <= stall_regs_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign stall_regs = stall_regs_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_control_p.sv
// tb_cache_control_p
// Directed bench for cache_control_p with 4-bit counters. Expected control
// vectors are pushed to a scoreboard queue as each step is driven and popped
// when the combinational outputs are sampled mid-cycle.
module tb_cache_control_p;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             mem_read, mem_write, cache_hit, hit1, lru_out, dirty_o, pmem_resp;
  logic             pmem_read, pmem_write, source_sel, way_sel, tag_sel, addrmux_sel;
  logic             load_cache, load_dirty, dirty_in, load_lru, stall, stall_regs;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  // Field order: pr pw ss ws ts am lc ld di ll st
  typedef struct packed {
    logic pmem_read;
    logic pmem_write;
    logic source_sel;
    logic way_sel;
    logic tag_sel;
    logic addrmux_sel;
    logic load_cache;
    logic load_dirty;
    logic dirty_in;
    logic load_lru;
    logic stall;
  } ctl_t;

  ctl_t exp_q[$];
  logic exp_prev_stall;
  int   vectors;
  int   miscompares;

  cache_control_p #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .cache_hit(cache_hit),
    .hit1(hit1), .lru_out(lru_out), .dirty_o(dirty_o), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .source_sel(source_sel),
    .way_sel(way_sel), .tag_sel(tag_sel), .addrmux_sel(addrmux_sel),
    .load_cache(load_cache), .load_dirty(load_dirty), .dirty_in(dirty_in),
    .load_lru(load_lru), .stall(stall), .stall_regs(stall_regs),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t mk(input logic pr, pw, ss, ws, ts, am, lc, ld, di, ll, st);
    return {pr, pw, ss, ws, ts, am, lc, ld, di, ll, st};
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input logic [CNT_W-1:0] obs,
                            input logic [CNT_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the live outputs,
  // plus stall_regs against the stall expected in the previous cycle.
  task automatic checkOutput(input string tag);
    ctl_t obs;
    ctl_t exp;
    obs = {pmem_read, pmem_write, source_sel, way_sel, tag_sel, addrmux_sel,
           load_cache, load_dirty, dirty_in, load_lru, stall};
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s ctl(pr pw ss ws ts am lc ld di ll st): observed %b expected %b",
             tag, obs, exp);
    end
    checkBit({tag, " stall_regs"}, stall_regs, exp_prev_stall);
    checkBit({tag, " rd/wr exclusive"}, pmem_read & pmem_write, 1'b0);
  endtask

  // Drives one cycle of inputs at the falling edge, checks mid-cycle,
  // then advances to the next falling edge.
  task automatic applyStimulus(input string tag, input logic rd, wr, hit, h1, lru, dty,
                               resp, input ctl_t exp);
    mem_read  = rd;
    mem_write = wr;
    cache_hit = hit;
    hit1      = h1;
    lru_out   = lru;
    dirty_o   = dty;
    pmem_resp = resp;
    exp_q.push_back(exp);
    #2;
    checkOutput(tag);
    @(posedge clk);
    @(negedge clk);
    exp_prev_stall = exp.stall;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    exp_prev_stall = 1'b0;
    rst       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cache_hit = 1'b0;
    hit1      = 1'b0;
    lru_out   = 1'b0;
    dirty_o   = 1'b0;
    pmem_resp = 1'b0;

    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
    checkOutput("reset idle");
    checkCount("reset hit_count", hit_count, 4'd0);
    checkCount("reset miss_count", miss_count, 4'd0);
    checkCount("reset wb_count", wb_count, 4'd0);
    rst = 1'b1;
    @(negedge clk);

    // Read hit in way 1
    applyStimulus("read hit", 1,0,1,1,0,0,0, mk(0,0,0,1,0,0,0,0,0,1,0));
    checkCount("read hit hit_count", hit_count, 4'd1);

    // Write hit in way 0
    applyStimulus("write hit", 0,1,1,0,0,0,0, mk(0,0,0,0,0,0,1,1,1,1,0));
    checkCount("write hit hit_count", hit_count, 4'd2);

    // Clean read miss, victim way 1, adaptor answers on the 4th cycle.
    // lru_out moves to 0 during the fill and must not retarget it.
    applyStimulus("clean miss", 1,0,0,0,1,0,0, mk(0,0,0,0,0,0,0,0,0,0,1));
    checkCount("clean miss miss_count", miss_count, 4'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus("clean fill wait", 1,0,0,0,0,0,0, mk(1,0,0,1,1,1,0,0,0,0,1));
    applyStimulus("clean fill resp", 1,0,0,0,0,0,1, mk(1,0,1,1,1,1,1,1,0,0,1));
    applyStimulus("clean refill", 1,0,0,0,0,0,0, mk(0,0,0,1,0,1,0,0,0,0,1));
    applyStimulus("clean complete", 1,0,1,1,0,0,0, mk(0,0,0,1,0,0,0,0,0,1,0));
    checkCount("clean complete hit_count", hit_count, 4'd3);
    checkCount("clean wb_count", wb_count, 4'd0);

    // Dirty write miss, victim way 0; writeback 3 cycles, fill 5 cycles.
    applyStimulus("dirty miss", 0,1,0,0,0,1,0, mk(0,0,0,0,0,0,0,0,0,0,1));
    checkCount("dirty miss miss_count", miss_count, 4'd2);
    for (int i = 0; i < 2; i++)
      applyStimulus("wb wait", 0,1,0,0,1,1,0, mk(0,1,0,0,0,1,0,0,0,0,1));
    applyStimulus("wb resp", 0,1,0,0,1,1,1, mk(0,1,0,0,0,1,0,0,0,0,1));
    checkCount("wb_count", wb_count, 4'd1);
    for (int i = 0; i < 4; i++)
      applyStimulus("dirty fill wait", 0,1,0,0,1,0,0, mk(1,0,0,0,1,1,0,0,0,0,1));
    applyStimulus("dirty fill resp", 0,1,0,0,1,0,1, mk(1,0,1,0,1,1,1,1,0,0,1));
    applyStimulus("dirty refill", 0,1,0,0,1,0,0, mk(0,0,0,0,0,1,0,0,0,0,1));
    applyStimulus("dirty complete", 0,1,1,0,1,0,0, mk(0,0,0,0,0,0,1,1,1,1,0));
    checkCount("dirty complete hit_count", hit_count, 4'd4);

    // Stray pmem_resp while idle must do nothing
    applyStimulus("stray resp", 0,0,0,0,0,0,1, mk(0,0,0,0,0,0,0,0,0,0,0));
    checkCount("stray resp wb_count", wb_count, 4'd1);
    checkCount("stray resp hit_count", hit_count, 4'd4);

    // Read and write together behaves as a write
    applyStimulus("rd+wr hit", 1,1,1,1,0,0,0, mk(0,0,0,1,0,0,1,1,1,1,0));
    checkCount("rd+wr hit_count", hit_count, 4'd5);

    // Reset asserted in the middle of a fill
    applyStimulus("abort miss", 1,0,0,0,1,0,0, mk(0,0,0,0,0,0,0,0,0,0,1));
    applyStimulus("abort fill", 1,0,0,0,1,0,0, mk(1,0,0,1,1,1,0,0,0,0,1));
    checkCount("abort miss_count", miss_count, 4'd3);
    mem_read = 1'b0;
    #1;
    checkBit("pre-abort pmem_read", pmem_read, 1'b1);
    rst = 1'b0;
    #1;
    checkBit("abort pmem_read", pmem_read, 1'b0);
    checkBit("abort stall", stall, 1'b0);
    checkBit("abort stall_regs", stall_regs, 1'b0);
    checkCount("abort hit_count", hit_count, 4'd0);
    checkCount("abort miss_count cleared", miss_count, 4'd0);
    checkCount("abort wb_count", wb_count, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_prev_stall = 1'b0;
    @(negedge clk);
    applyStimulus("post-abort hit", 1,0,1,0,0,0,0, mk(0,0,0,0,0,0,0,0,0,1,0));
    checkCount("post-abort hit_count", hit_count, 4'd1);

    // Saturation: 15 hits reach 15, further hits stay there
    for (int i = 0; i < 14; i++)
      applyStimulus("sat hit", 1,0,1,1,0,0,0, mk(0,0,0,1,0,0,0,0,0,1,0));
    checkCount("sat at 15", hit_count, 4'd15);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("sat extra hit", 1,0,1,1,0,0,0, mk(0,0,0,1,0,0,0,0,0,1,0));
      checkCount("sat held", hit_count, 4'd15);
    end

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL scoreboard drain: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
